// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Purpose  : Single-command APB requester with back-to-back chaining; optional
//            ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  pclk,
   input  logic                  prst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   output logic                  t_valid,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic                  w_accept;
   logic                  w_timeout;
   logic                  w_rsp_valid_next;
   logic                  w_rsp_err_next;
   logic [DATA_WIDTH-1:0] w_rsp_rdata_next;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("apb_master_bridge: TIMEOUT_CYCLES must be >= 2");
   end

`ifdef APB_TIMEOUT_EN
   localparam int              CNT_W      = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;

   // Counts ACCESS cycles that ended without pready; cleared outside ACCESS.
   always_ff @(posedge pclk or negedge prst) begin
      if (!prst) begin
         r_cnt <= '0;
      end else if (r_state == ST_ACCESS && !pready && !w_timeout) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end

   assign w_timeout = (r_state == ST_ACCESS) && !pready && (r_cnt == C_CNT_LAST);
`else
   assign w_timeout = 1'b0;
`endif

   assign psel      = (r_state != ST_IDLE);
   assign penable   = (r_state == ST_ACCESS);
   assign cmd_ready = (r_state == ST_IDLE) || (r_state == ST_ACCESS && pready);
   assign t_valid   = (r_state == ST_ACCESS) && cmd_valid;
   assign w_accept  = cmd_valid && cmd_ready;

   always_comb begin
      w_state_next     = r_state;
      w_rsp_valid_next = 1'b0;
      w_rsp_err_next   = 1'b0;
      w_rsp_rdata_next = '0;
      case (r_state)
         ST_IDLE: begin
            if (cmd_valid) begin
               w_state_next = ST_SETUP;
            end
         end
         ST_SETUP: begin
            w_state_next = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (pready) begin
               w_rsp_valid_next = 1'b1;
               w_rsp_rdata_next = pwrite ? '0 : prdata;
               // A waiting command chains straight into SETUP, keeping psel high.
               w_state_next     = cmd_valid ? ST_SETUP : ST_IDLE;
            end else if (w_timeout) begin
               w_rsp_valid_next = 1'b1;
               w_rsp_err_next   = 1'b1;
               w_state_next     = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge prst) begin
      if (!prst) begin
         r_state   <= ST_IDLE;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         rsp_valid <= w_rsp_valid_next;
         rsp_rdata <= w_rsp_rdata_next;
         rsp_err   <= w_rsp_err_next;
         if (w_accept) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// Testbench for apb_master_bridge: directed scenarios plus randomized
// transfers checked against a slave-memory reference model.
module tb_apb_master_bridge;

   logic        pclk = 1'b0;
   logic        prst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [3:0]  cmd_addr;
   logic [15:0] cmd_wdata;
   logic        rsp_valid, rsp_err;
   logic [15:0] rsp_rdata;
   logic        psel, penable, pwrite, t_valid, pready;
   logic [3:0]  paddr;
   logic [15:0] pwdata, prdata;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] mem [16];

   always #5 pclk = ~pclk;

   apb_master_bridge #(
      .DATA_WIDTH(16), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(8)
   ) dut (
      .pclk(pclk), .prst(prst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .t_valid(t_valid), .prdata(prdata), .pready(pready)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One transfer from IDLE with `waits` wait states; checks every APB cycle.
   task automatic run_xfer(input logic wr, input logic [3:0] a, input logic [15:0] d,
                           input int waits);
      logic [15:0] exp;
      exp = wr ? 16'h0000 : mem[a];
      @(negedge pclk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      #1;
      chk("idle_ready", cmd_ready, 1);
      chk("idle_psel", psel, 0);
      @(negedge pclk);
      cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 4'($urandom);
      cmd_wdata = 16'($urandom);
      #1;
      chk("setup_psel", psel, 1);
      chk("setup_penable", penable, 0);
      chk("setup_paddr", paddr, a);
      chk("setup_pwrite", pwrite, wr);
      chk("setup_ready", cmd_ready, 0);
      if (wr) chk("setup_pwdata", pwdata, d);
      for (int w = 0; w <= waits; w++) begin
         @(negedge pclk);
         pready = (w == waits);
         prdata = (w == waits && !wr) ? mem[a] : 16'($urandom);
         #1;
         chk("acc_psel", psel, 1);
         chk("acc_penable", penable, 1);
         chk("acc_paddr", paddr, a);
         chk("acc_pwrite", pwrite, wr);
         chk("acc_ready", cmd_ready, (w == waits));
         chk("acc_rsp_idle", rsp_valid, 0);
         if (wr) chk("acc_pwdata", pwdata, d);
      end
      if (wr) mem[a] = d;
      @(negedge pclk);
      pready = 1'b0; prdata = 16'($urandom);
      #1;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_rdata", rsp_rdata, exp);
      chk("rsp_err", rsp_err, 0);
      chk("rsp_psel", psel, 0);
      @(negedge pclk);
      #1;
      chk("rsp_one_cycle", rsp_valid, 0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
      prst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; pready = 1'b0; prdata = '0;
      #1;
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_pwdata", pwdata, 0);
      chk("rst_pwrite", pwrite, 0);
      repeat (2) @(negedge pclk);
      prst = 1'b1;
      #1;
      chk("rst_release_ready", cmd_ready, 1);

      // Basic write then read-back, zero wait states.
      run_xfer(1'b1, 4'h3, 16'hA5A5, 0);
      run_xfer(1'b0, 4'h3, 16'h0000, 0);

      // Back-to-back writes with cmd_valid held across the chain.
      @(negedge pclk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h1; cmd_wdata = 16'h0011;
      #1;
      chk("b2b_ready0", cmd_ready, 1);
      @(negedge pclk);
      cmd_addr = 4'h2; cmd_wdata = 16'h0022;
      #1;
      chk("b2b_setup1_penable", penable, 0);
      chk("b2b_setup1_paddr", paddr, 4'h1);
      chk("b2b_setup1_tvalid", t_valid, 0);
      @(negedge pclk);
      pready = 1'b1;
      #1;
      chk("b2b_acc1_tvalid", t_valid, 1);
      chk("b2b_acc1_ready", cmd_ready, 1);
      chk("b2b_acc1_penable", penable, 1);
      @(negedge pclk);
      cmd_valid = 1'b0; pready = 1'b0;
      #1;
      chk("b2b_setup2_psel", psel, 1);
      chk("b2b_setup2_penable", penable, 0);
      chk("b2b_setup2_paddr", paddr, 4'h2);
      chk("b2b_setup2_pwdata", pwdata, 16'h0022);
      chk("b2b_rsp1", rsp_valid, 1);
      @(negedge pclk);
      pready = 1'b1;
      #1;
      chk("b2b_acc2_penable", penable, 1);
      chk("b2b_acc2_rsp_gap", rsp_valid, 0);
      chk("b2b_acc2_tvalid", t_valid, 0);
      @(negedge pclk);
      pready = 1'b0;
      #1;
      chk("b2b_rsp2", rsp_valid, 1);
      chk("b2b_end_psel", psel, 0);
      mem[1] = 16'h0011; mem[2] = 16'h0022;
      @(negedge pclk);
      #1;
      chk("b2b_rsp2_width", rsp_valid, 0);

      // Five wait states, then read the chained writes back.
      run_xfer(1'b1, 4'h9, 16'h1234, 5);
      run_xfer(1'b0, 4'h9, 16'h0000, 5);
      run_xfer(1'b0, 4'h2, 16'h0000, 1);

      // Asynchronous reset in the middle of ACCESS.
      @(negedge pclk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h5;
      @(negedge pclk);
      cmd_valid = 1'b0;
      @(negedge pclk);
      #1;
      chk("arst_pre_penable", penable, 1);
      #2;
      prst = 1'b0;
      #1;
      chk("arst_psel", psel, 0);
      chk("arst_penable", penable, 0);
      chk("arst_rsp_valid", rsp_valid, 0);
      @(negedge pclk);
      prst = 1'b1;
      @(negedge pclk);
      #1;
      chk("arst_no_rsp", rsp_valid, 0);
      run_xfer(1'b0, 4'h0, 16'h0000, 0);

`ifdef APB_TIMEOUT_EN
      @(negedge pclk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h7; cmd_wdata = 16'hBEEF;
      @(negedge pclk);
      cmd_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge pclk);
         pready = 1'b0;
         #1;
         chk("to_acc_penable", penable, 1);
         chk("to_acc_ready", cmd_ready, 0);
      end
      @(negedge pclk);
      #1;
      chk("to_psel", psel, 0);
      chk("to_rsp_valid", rsp_valid, 1);
      chk("to_rsp_err", rsp_err, 1);
      chk("to_rsp_rdata", rsp_rdata, 0);
      @(negedge pclk);
      #1;
      chk("to_rsp_width", rsp_valid, 0);
      run_xfer(1'b0, 4'h7, 16'h0000, 7);
`endif

      // Randomized transfers against the slave memory model.
      for (int i = 0; i < 24; i++) begin
         run_xfer(1'($urandom), 4'($urandom), 16'($urandom), int'($urandom_range(0, 4)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester (initiator) for the File2Bus data path; drives the APB slave memory side.
- Accepts single read/write commands on a valid/ready command port and sequences APB SETUP/ACCESS phases.
- Waits on pready and returns read data or write completion on a one-cycle response pulse.
- Drives t_valid so the slave can chain back-to-back transfers without returning to IDLE.

Parameters:
- DATA_WIDTH, 16, width of pwdata/prdata and command/response data
- ADDR_WIDTH, 4, width of paddr and cmd_addr
- TIMEOUT_CYCLES, 16, max ACCESS cycles without pready (used only with APB_TIMEOUT_EN); must be >=2

Ports:
- pclk  input  1  single clock; all logic rising-edge
- prst  input  1  reset, asynchronous assert, active-low (0 = reset)
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready at rising edge
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  ADDR_WIDTH  transfer address
- cmd_wdata  input  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes
- rsp_err  output  1  transfer aborted by timeout (always 0 without APB_TIMEOUT_EN)
- psel  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- paddr  output  ADDR_WIDTH  APB address
- pwdata  output  DATA_WIDTH  APB write data
- t_valid  output  1  next transfer queued (to slave)
- prdata  input  DATA_WIDTH  APB read data
- pready  input  1  APB transfer complete

Behaviour:
- Reset (prst=0, async): state=IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err all 0. cmd_ready=1 once prst releases. An in-flight transfer is dropped with no response.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - psel=0, penable=0, cmd_ready=1.
  - On handshake: latch cmd_write/addr/wdata into pwrite/paddr/pwdata; next state SETUP.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0, cmd_ready=0; next state ACCESS.
- ACCESS:
  - psel=1, penable=1; paddr/pwrite/pwdata held stable.
  - Remains in ACCESS while pready=0 (unbounded wait states).
  - On the edge where pready=1:
    - If read, register prdata into rsp_rdata; if write, set rsp_rdata=0.
    - rsp_valid=1 for the following cycle only.
    - If cmd_valid=1, accept the next command on this same edge and go to SETUP, keeping psel high with penable low; otherwise go to IDLE with psel=0.
- cmd_ready is combinational: (state==IDLE) || (state==ACCESS && pready).
- t_valid is combinational: (state==ACCESS) && cmd_valid.
- rsp_valid has no backpressure; the consumer must accept it.
- Latency:
  - Handshake at edge N gives SETUP in N..N+1 and ACCESS from N+1.
  - With zero wait states, pready is sampled at N+2 and rsp_valid is high in N+2..N+3.
  - Minimum 2 cycles per transfer; back-to-back sustains 1 transfer per 2 cycles plus wait states.
- cmd_* inputs are ignored unless a handshake occurs. pready and prdata are ignored outside ACCESS.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - ACCESS-cycle counter starts at 0 on entry to ACCESS.
  - If pready is still 0 after TIMEOUT_CYCLES ACCESS cycles: drop psel and penable, go to IDLE, pulse rsp_valid=1 with rsp_err=1 and rsp_rdata=0.
  - cmd_ready is 0 on the timeout edge; no chaining after a timeout.
  - pready=1 on the final counted cycle completes normally (rsp_err=0).
- Not defined: no counter, rsp_err tied 0, ACCESS waits indefinitely.

Test Plan:
- Write addr 4'h3 data 16'hA5A5, zero-wait slave -> one SETUP cycle (psel=1, penable=0, paddr=3, pwrite=1, pwdata=A5A5), one ACCESS cycle, rsp_valid pulse 1 cycle, rsp_rdata=0, rsp_err=0.
- Read addr 4'h3 with the slave returning 16'hA5A5 -> rsp_rdata=16'hA5A5, pwrite=0 throughout, and the rsp_valid pulse is exactly one cycle wide.
- Back-to-back writes (addr 1/16'h0011, then addr 2/16'h0022) with cmd_valid held ->
  - t_valid=1 in the first ACCESS;
  - psel never drops; penable low for exactly one cycle between transfers;
  - two rsp_valid pulses 2 cycles apart.
- pready delayed 5 cycles -> penable/paddr/pwdata stable all 5 cycles, cmd_ready=0, exactly one rsp_valid.
- prst=0 asserted mid-ACCESS (asynchronously, between clock edges) -> psel, penable and rsp_valid go to 0 immediately without a clock edge; no response; after release a new read of addr 4'h0 completes normally.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and pready tied 0 -> after 8 ACCESS cycles psel=0, rsp_valid=1, rsp_err=1, rsp_rdata=0; the next command is accepted from IDLE.
